pcs_rx_link_ctrl: RTL and testbench
===================================

Name: pcs_rx_link_ctrl

Overview:
- Receive-side link bring-up and retrain sequencer for the 10GBASE-R PCS (eth_phy_10g).
- Pulses the SERDES RX reset, waits for block lock, then requires a stable no-high-BER window before declaring link up.
- Monitors for loss of lock, high BER or a PHY reset request, and forces a retrain when any occurs.
- Accumulates rx_error_count while the link is up; the result is exported to status registers and benches.

Parameters:
- RESET_CYCLES, 16, cycles serdes_rx_reset is held high per reset attempt (1..255).
- LOCK_TIMEOUT, 1024, cycles allowed in WAIT_LOCK before retry (>= 2).
- STABLE_CYCLES, 125, consecutive cycles of lock && !high_ber required before LINK_UP (matches COUNT_125US scaling).
- ERR_ACC_WIDTH, 16, width of the saturating error accumulator.

Ports:
- rx_clk  in  1  receive clock.
- rx_rst  in  1  reset; asynchronous, active-high.
- cfg_enable  in  1  0 forces IDLE; 1 starts bring-up.
- rx_block_lock  in  1  from PHY.
- rx_high_ber  in  1  from PHY.
- serdes_rx_reset_req  in  1  from PHY; requests SERDES reset.
- rx_error_count  in  7  per-cycle errored-block count from PHY.
- err_clear  in  1  clears err_accum.
- serdes_rx_reset  out  1  reset to SERDES RX.
- link_up  out  1  high only in LINK_UP.
- link_state  out  3  encoded FSM state.
- retrain_count  out  8  saturating count of retrains and timeouts.
- err_accum  out  ERR_ACC_WIDTH  saturating sum of rx_error_count during LINK_UP.

Behaviour:
- Reset values:
  - state = IDLE (0); serdes_rx_reset = 0; link_up = 0.
  - retrain_count = 0; err_accum = 0; internal timer = 0.
- All outputs are registered.
- States and encodings: IDLE = 0, SERDES_RST = 1, WAIT_LOCK = 2, WAIT_STABLE = 3, LINK_UP = 4, LINK_DOWN = 5.
- IDLE:
  - Outputs low.
  - cfg_enable = 1 → SERDES_RST, timer = 0.
- SERDES_RST:
  - serdes_rx_reset = 1 for exactly RESET_CYCLES cycles, then → WAIT_LOCK, timer = 0.
  - serdes_rx_reset is high in the cycle after entry and low in the cycle after exit.
- WAIT_LOCK:
  - rx_block_lock = 1 → WAIT_STABLE, timer = 0.
  - Timer reaching LOCK_TIMEOUT-1 without lock → SERDES_RST, retrain_count += 1.
  - If lock and timeout occur in the same cycle, lock wins.
- WAIT_STABLE:
  - Timer increments while rx_block_lock && !rx_high_ber.
  - Any cycle failing that condition resets the timer to 0 (no state change), except loss of rx_block_lock, which → WAIT_LOCK.
  - Timer reaching STABLE_CYCLES-1 → LINK_UP.
- LINK_UP:
  - link_up = 1.
  - err_accum += rx_error_count each cycle, saturating at all-ones.
  - Any of !rx_block_lock, rx_high_ber or serdes_rx_reset_req → LINK_DOWN.
- LINK_DOWN:
  - Lasts one cycle: retrain_count += 1, then → SERDES_RST.
- cfg_enable = 0 in any state → IDLE next cycle; this overrides every other transition.
- serdes_rx_reset_req = 1 in WAIT_LOCK or WAIT_STABLE → SERDES_RST, retrain_count += 1.
- err_accum and retrain_count:
  - retrain_count saturates at 255.
  - err_clear has priority over the accumulate: err_clear and a nonzero error count in the same cycle gives err_accum = 0.
- Reset asserted mid-operation:
  - All state returns to reset values immediately (asynchronous).
  - serdes_rx_reset drops to 0 immediately.

Optional Feature:
- Macro: PCS_RX_LINK_CTRL_IRQ_EN.
- Defined:
  - Adds input irq_clear (1) and output link_irq (1).
  - link_irq is sticky: set in the cycle after link_up changes in either direction; cleared by irq_clear.
  - A set event wins over a simultaneous clear.
  - Resets to 0.
- Undefined: the ports are absent and no logic is generated.

Decomposition:
- Package pcs_rx_link_ctrl_pkg holds:
  - the state enum (3-bit, encodings as above);
  - LINK_STATE_W = 3;
  - RETRAIN_W = 8;
  - a saturating-add helper function.
- One sub-module, pcs_link_timer: loadable up-counter with a clear and a terminal-count compare.
  - Shared by the SERDES_RST, WAIT_LOCK and WAIT_STABLE phases.

Test Plan:
- Clean bring-up: cfg_enable = 1, lock asserted 3 cycles after serdes_rx_reset falls, high_ber = 0.
  - Expect serdes_rx_reset high exactly 16 cycles.
  - Expect link_up at WAIT_STABLE entry + 125 cycles.
  - Expect retrain_count = 0.
- Lock timeout: rx_block_lock held 0.
  - Expect a new 16-cycle serdes_rx_reset pulse after every 1024 cycles in WAIT_LOCK.
  - Expect retrain_count = 3 after three timeouts.
- Stability restart: in WAIT_STABLE, pulse rx_high_ber for 1 cycle at timer = 100.
  - Expect link_up a further 125 cycles after the pulse.
  - Expect no serdes_rx_reset.
- Link loss: in LINK_UP, drop rx_block_lock for 1 cycle.
  - Expect link_up = 0 next cycle, link_state = 5 for 1 cycle, then a serdes_rx_reset pulse.
  - Expect retrain_count to increment by 1.
- Error accumulation: in LINK_UP, drive rx_error_count = 7 for 10 cycles.
  - Expect err_accum = 70.
  - With ERR_ACC_WIDTH = 8, 50 cycles of 7 → err_accum = 255.
  - err_clear asserted with rx_error_count = 7 → err_accum = 0.
- Async reset mid-pulse: assert rx_rst during SERDES_RST, off-clock-edge.
  - Expect serdes_rx_reset, link_state and retrain_count = 0 before the next rx_clk edge.

Source files
------------

// File: rtl/pcs_rx_link_ctrl_pkg.sv
// Shared types, widths and saturating arithmetic for the 10GBASE-R RX link controller.
// Pure declarations: no latency, no flow control.
package pcs_rx_link_ctrl_pkg;

  localparam int LINK_STATE_W = 3;
  localparam int RETRAIN_W    = 8;

  typedef enum logic [LINK_STATE_W-1:0] {
    ST_IDLE        = 3'd0,
    ST_SERDES_RST  = 3'd1,
    ST_WAIT_LOCK   = 3'd2,
    ST_WAIT_STABLE = 3'd3,
    ST_LINK_UP     = 3'd4,
    ST_LINK_DOWN   = 3'd5
  } link_state_e;

  // Callers size-cast operands up to 32 bits and cast the result back down.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
  endfunction

endpackage

// File: rtl/pcs_link_timer.sv
// Loadable up-counter with clear and terminal-count compare, shared by the timed FSM phases.
// Latency: count updates one cycle after clr/load/inc; tc_hit is combinational on the count. No backpressure.
module pcs_link_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] tc_val,
  output logic         tc_hit
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_hit = (cnt_q == tc_val);

endmodule

// File: rtl/pcs_rx_link_ctrl.sv
// RX link bring-up/retrain sequencer; registered outputs, 1-cycle latency, no backpressure.
// Optional link-change interrupt enabled by defining PCS_RX_LINK_CTRL_IRQ_EN.
module pcs_rx_link_ctrl
  import pcs_rx_link_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int STABLE_CYCLES = 125,
  parameter int ERR_ACC_WIDTH = 16
) (
  input  logic                     rx_clk,
  input  logic                     rx_rst,
  input  logic                     cfg_enable,
  input  logic                     rx_block_lock,
  input  logic                     rx_high_ber,
  input  logic                     serdes_rx_reset_req,
  input  logic [6:0]               rx_error_count,
  input  logic                     err_clear,
`ifdef PCS_RX_LINK_CTRL_IRQ_EN
  input  logic                     irq_clear,
  output logic                     link_irq,
`endif
  output logic                     serdes_rx_reset,
  output logic                     link_up,
  output logic [LINK_STATE_W-1:0]  link_state,
  output logic [RETRAIN_W-1:0]     retrain_count,
  output logic [ERR_ACC_WIDTH-1:0] err_accum
);

  localparam int TMR_MAX_A = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int TMR_MAX   = (TMR_MAX_A > STABLE_CYCLES) ? TMR_MAX_A : STABLE_CYCLES;
  localparam int TMR_W     = $clog2(TMR_MAX);

  localparam logic [RETRAIN_W-1:0]     RETRAIN_MAX = '1;
  localparam logic [ERR_ACC_WIDTH-1:0] ERR_MAX     = '1;

  link_state_e state_q, state_d;

  logic                     serdes_rx_reset_q, serdes_rx_reset_d;
  logic                     link_up_q, link_up_d;
  logic [RETRAIN_W-1:0]     retrain_q, retrain_d;
  logic [ERR_ACC_WIDTH-1:0] err_q, err_d;

  logic             tmr_clr;
  logic             tmr_inc;
  logic             tmr_hit;
  logic [TMR_W-1:0] tmr_tc;
  logic             retrain_inc;

  // One timer serves all timed phases; only the terminal value changes per state.
  always_comb begin
    case (state_q)
      ST_SERDES_RST: tmr_tc = TMR_W'(RESET_CYCLES - 1);
      ST_WAIT_LOCK:  tmr_tc = TMR_W'(LOCK_TIMEOUT - 1);
      default:       tmr_tc = TMR_W'(STABLE_CYCLES - 1);
    endcase
  end

  pcs_link_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (rx_clk),
    .rst      (rx_rst),
    .clr      (tmr_clr),
    .load     (1'b0),
    .load_val ('0),
    .inc      (tmr_inc),
    .tc_val   (tmr_tc),
    .tc_hit   (tmr_hit)
  );

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Disable beats everything; a PHY reset request beats lock; lock beats timeout.
  always_comb begin
    state_d     = state_q;
    tmr_clr     = 1'b0;
    tmr_inc     = 1'b0;
    retrain_inc = 1'b0;
    if (!cfg_enable) begin
      state_d = ST_IDLE;
      tmr_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SERDES_RST;
          tmr_clr = 1'b1;
        end
        ST_SERDES_RST: begin
          if (tmr_hit) begin
            state_d = ST_WAIT_LOCK;
            tmr_clr = 1'b1;
          end else begin
            tmr_inc = 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (serdes_rx_reset_req) begin
            state_d     = ST_SERDES_RST;
            tmr_clr     = 1'b1;
            retrain_inc = 1'b1;
          end else if (rx_block_lock) begin
            state_d = ST_WAIT_STABLE;
            tmr_clr = 1'b1;
          end else if (tmr_hit) begin
            state_d     = ST_SERDES_RST;
            tmr_clr     = 1'b1;
            retrain_inc = 1'b1;
          end else begin
            tmr_inc = 1'b1;
          end
        end
        ST_WAIT_STABLE: begin
          if (serdes_rx_reset_req) begin
            state_d     = ST_SERDES_RST;
            tmr_clr     = 1'b1;
            retrain_inc = 1'b1;
          end else if (!rx_block_lock) begin
            state_d = ST_WAIT_LOCK;
            tmr_clr = 1'b1;
          end else if (rx_high_ber) begin
            tmr_clr = 1'b1;
          end else if (tmr_hit) begin
            state_d = ST_LINK_UP;
            tmr_clr = 1'b1;
          end else begin
            tmr_inc = 1'b1;
          end
        end
        ST_LINK_UP: begin
          if (!rx_block_lock || rx_high_ber || serdes_rx_reset_req) begin
            state_d = ST_LINK_DOWN;
          end
        end
        ST_LINK_DOWN: begin
          state_d     = ST_SERDES_RST;
          tmr_clr     = 1'b1;
          retrain_inc = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          tmr_clr = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    serdes_rx_reset_d = (state_d == ST_SERDES_RST);
    link_up_d         = (state_d == ST_LINK_UP);

    retrain_d = retrain_q;
    if (retrain_inc) begin
      retrain_d = RETRAIN_W'(sat_add(32'(retrain_q), 32'd1, 32'(RETRAIN_MAX)));
    end

    err_d = err_q;
    if (err_clear) begin
      err_d = '0;
    end else if (state_q == ST_LINK_UP) begin
      err_d = ERR_ACC_WIDTH'(sat_add(32'(err_q), 32'(rx_error_count), 32'(ERR_MAX)));
    end
  end

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      serdes_rx_reset_q <= 1'b0;
      link_up_q         <= 1'b0;
      retrain_q         <= '0;
      err_q             <= '0;
    end else begin
      serdes_rx_reset_q <= serdes_rx_reset_d;
      link_up_q         <= link_up_d;
      retrain_q         <= retrain_d;
      err_q             <= err_d;
    end
  end

  assign serdes_rx_reset = serdes_rx_reset_q;
  assign link_up         = link_up_q;
  assign link_state      = state_q;
  assign retrain_count   = retrain_q;
  assign err_accum       = err_q;

`ifdef PCS_RX_LINK_CTRL_IRQ_EN
  logic link_up_prev_q;
  logic link_irq_q, link_irq_d;

  // Set wins over clear so a link change is never lost to a concurrent acknowledge.
  always_comb begin
    link_irq_d = (link_up_q != link_up_prev_q) | (link_irq_q & ~irq_clear);
  end

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      link_up_prev_q <= 1'b0;
      link_irq_q     <= 1'b0;
    end else begin
      link_up_prev_q <= link_up_q;
      link_irq_q     <= link_irq_d;
    end
  end

  assign link_irq = link_irq_q;
`endif

endmodule

// File: tb/tb_pcs_rx_link_ctrl.sv
// Bench for pcs_rx_link_ctrl: directed bring-up/retrain scenarios then randomized traffic,
// every cycle compared against a phase/elapsed-cycle reference model.
module tb_pcs_rx_link_ctrl;

  localparam int RC      = 16;
  localparam int LT      = 1024;
  localparam int SC      = 125;
  localparam int EW      = 8;
  localparam int ERR_MAX = 255;

  localparam int P_IDLE = 0, P_SRST = 1, P_WLOCK = 2, P_WSTAB = 3, P_UP = 4, P_DOWN = 5;

  logic          rx_clk = 1'b0;
  logic          rx_rst;
  logic          en, lock, ber, req, clr;
  logic [6:0]    ec;
  logic          serdes_rx_reset, link_up;
  logic [2:0]    link_state;
  logic [7:0]    retrain_count;
  logic [EW-1:0] err_accum;
`ifdef PCS_RX_LINK_CTRL_IRQ_EN
  logic          irq_clear = 1'b0;
  logic          link_irq;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Reference model: current phase, cycles elapsed in the phase's timed window, counters.
  int ph, elapsed, m_retrain, m_err;

  always #5 rx_clk = ~rx_clk;

  pcs_rx_link_ctrl #(
    .RESET_CYCLES  (RC),
    .LOCK_TIMEOUT  (LT),
    .STABLE_CYCLES (SC),
    .ERR_ACC_WIDTH (EW)
  ) dut (
    .rx_clk              (rx_clk),
    .rx_rst              (rx_rst),
    .cfg_enable          (en),
    .rx_block_lock       (lock),
    .rx_high_ber         (ber),
    .serdes_rx_reset_req (req),
    .rx_error_count      (ec),
    .err_clear           (clr),
`ifdef PCS_RX_LINK_CTRL_IRQ_EN
    .irq_clear           (irq_clear),
    .link_irq            (link_irq),
`endif
    .serdes_rx_reset     (serdes_rx_reset),
    .link_up             (link_up),
    .link_state          (link_state),
    .retrain_count       (retrain_count),
    .err_accum           (err_accum)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = P_IDLE; elapsed = 0; m_retrain = 0; m_err = 0;
  endtask

  task automatic model_step();
    int  nph;
    int  nel;
    bit  retrain;
    nph = ph; nel = elapsed + 1; retrain = 0;
    if (!en) begin
      nph = P_IDLE; nel = 0;
    end else begin
      case (ph)
        P_IDLE: begin nph = P_SRST; nel = 0; end
        P_SRST: if (elapsed + 1 == RC) begin nph = P_WLOCK; nel = 0; end
        P_WLOCK: begin
          if (req) begin nph = P_SRST; nel = 0; retrain = 1; end
          else if (lock) begin nph = P_WSTAB; nel = 0; end
          else if (elapsed + 1 == LT) begin nph = P_SRST; nel = 0; retrain = 1; end
        end
        P_WSTAB: begin
          if (req) begin nph = P_SRST; nel = 0; retrain = 1; end
          else if (!lock) begin nph = P_WLOCK; nel = 0; end
          else if (ber) nel = 0;
          else if (elapsed + 1 == SC) begin nph = P_UP; nel = 0; end
        end
        P_UP: begin
          nel = 0;
          if (!lock || ber || req) nph = P_DOWN;
        end
        default: begin nph = P_SRST; nel = 0; retrain = 1; end
      endcase
    end
    if (clr) m_err = 0;
    else if (ph == P_UP) m_err = (m_err + int'(ec) > ERR_MAX) ? ERR_MAX : m_err + int'(ec);
    if (retrain && m_retrain < 255) m_retrain++;
    ph = nph; elapsed = nel;
  endtask

  task automatic tick();
    @(posedge rx_clk);
    model_step();
    #1;
    check_val("state",   link_state,      ph);
    check_val("link_up", link_up,         ph == P_UP);
    check_val("srst",    serdes_rx_reset, ph == P_SRST);
    check_val("retrain", retrain_count,   m_retrain);
    check_val("err",     err_accum,       m_err);
  endtask

  task automatic wait_state(input int st, input int limit);
    int n;
    n = 0;
    while (int'(link_state) != st && n < limit) begin tick(); n++; end
    check_val("reach_state", link_state, st);
  endtask

  initial begin
    int n, r0, seen;
    rx_rst = 1'b1; en = 0; lock = 0; ber = 0; req = 0; clr = 0; ec = '0;
    model_reset();
    repeat (2) @(posedge rx_clk);
    #1;
    check_val("rst_state",   link_state,      0);
    check_val("rst_srst",    serdes_rx_reset, 0);
    check_val("rst_up",      link_up,         0);
    check_val("rst_retrain", retrain_count,   0);
    check_val("rst_err",     err_accum,       0);
    rx_rst = 1'b0;

    // Clean bring-up
    repeat (3) tick();
    en = 1;
    n = 0;
    while (!serdes_rx_reset && n < 10) begin tick(); n++; end
    check_val("srst_rise", serdes_rx_reset, 1);
    n = 0;
    while (serdes_rx_reset && n < 100) begin tick(); n++; end
    check_val("srst_width", n, RC);
    repeat (2) tick();
    lock = 1;
    wait_state(P_WSTAB, 20);
    n = 0;
    while (!link_up && n < 500) begin tick(); n++; end
    check_val("stable_len", n, SC);
    check_val("bringup_retrain", retrain_count, 0);

    // Error accumulation and saturation (8-bit accumulator)
    ec = 7'd7;
    repeat (10) tick();
    check_val("err_70", err_accum, 70);
    repeat (50) tick();
    check_val("err_sat", err_accum, 255);
    clr = 1; tick(); clr = 0; ec = '0;
    check_val("err_clear", err_accum, 0);

    // Link loss
    r0 = int'(retrain_count);
    lock = 0; tick(); lock = 1;
    check_val("loss_up", link_up, 0);
    check_val("loss_state", link_state, P_DOWN);
    tick();
    check_val("loss_srst", serdes_rx_reset, 1);
    check_val("loss_retrain", retrain_count, r0 + 1);

    // Stability restart: one high-BER cycle at timer = 100
    wait_state(P_WSTAB, 100);
    repeat (100) tick();
    ber = 1; tick(); ber = 0;
    n = 0; seen = 0;
    while (!link_up && n < 500) begin
      tick(); n++;
      if (serdes_rx_reset) seen++;
    end
    check_val("restart_len", n, SC);
    check_val("restart_nosrst", seen, 0);

    // Async reset in the middle of a SERDES reset pulse
    lock = 0;
    repeat (4) tick();
    check_val("pre_arst_srst", serdes_rx_reset, 1);
    #2 rx_rst = 1'b1;
    #1;
    model_reset();
    check_val("arst_srst",    serdes_rx_reset, 0);
    check_val("arst_state",   link_state,      0);
    check_val("arst_retrain", retrain_count,   0);
    @(posedge rx_clk);
    #1 rx_rst = 1'b0;

    // Lock timeouts with lock held low
    n = 0;
    while (!serdes_rx_reset && n < 10) begin tick(); n++; end
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (serdes_rx_reset && n < 100) begin tick(); n++; end
      check_val("to_srst_width", n, RC);
      n = 0;
      while (int'(link_state) == P_WLOCK && n < 2000) begin tick(); n++; end
      check_val("to_wlock_len", n, LT);
    end
    check_val("to_retrain3", retrain_count, 3);

    // Randomized traffic
    for (int i = 0; i < 20000; i++) begin
      en   = ($urandom_range(0, 1999) != 0);
      lock = ($urandom_range(0, 399) != 0);
      ber  = ($urandom_range(0, 299) == 0);
      req  = ($urandom_range(0, 599) == 0);
      clr  = ($urandom_range(0, 49) == 0);
      ec   = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 3));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
